// File: rtl/alu_operand_sequencer.sv
// Captures operand A, then operand B plus opcode, on two debounced load-button presses
// and hands the stable {A,B,op} tuple to the ALU over a valid/ready handshake.
module alu_operand_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic [3:0] din,
  input  logic [1:0] op_in,
  input  logic       load_btn,
  output logic [3:0] a_out,
  output logic [3:0] b_out,
  output logic [1:0] op_out,
  output logic       issue_valid,
  input  logic       issue_ready,
  output logic [1:0] stage,
  output logic [3:0] op_count
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_A = 2'b00,
    WAIT_B = 2'b01,
    ISSUE  = 2'b10
  } stage_e;

  stage_e           state_q, state_d;
  logic             sync1, sync2;
  logic [CNT_W-1:0] deb_cnt, deb_cnt_d;
  logic             deb_lvl, deb_lvl_d;
  logic             deb_prev;
  logic             load_pulse;
  logic [3:0]       a_d, b_d, count_d;
  logic [1:0]       op_d;

  assign load_pulse = deb_lvl & ~deb_prev;
  assign stage      = state_q;

  // Debounce: level is accepted once sync2 has disagreed with it for DEBOUNCE_CYCLES cycles
  always_comb begin
    deb_cnt_d = deb_cnt;
    deb_lvl_d = deb_lvl;
    if (ena) begin
      if (sync2 == deb_lvl) begin
        deb_cnt_d = '0;
      end else if (deb_cnt == CNT_LAST) begin
        deb_cnt_d = '0;
        deb_lvl_d = sync2;
      end else begin
        deb_cnt_d = deb_cnt + CNT_W'(1);
      end
    end
  end

  // Sequencer next-state and capture logic
  always_comb begin
    state_d = state_q;
    a_d     = a_out;
    b_d     = b_out;
    op_d    = op_out;
    count_d = op_count;
    if (ena) begin
      case (state_q)
        WAIT_A: if (load_pulse) begin
          a_d     = din;
          state_d = WAIT_B;
        end
        WAIT_B: if (load_pulse) begin
          b_d     = din;
          op_d    = op_in;
          state_d = ISSUE;
        end
        ISSUE: if (issue_ready) begin
          count_d = op_count + 4'd1;
          state_d = WAIT_A;
        end
        default: state_d = WAIT_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      deb_cnt     <= '0;
      deb_lvl     <= 1'b0;
      deb_prev    <= 1'b0;
      state_q     <= WAIT_A;
      a_out       <= 4'd0;
      b_out       <= 4'd0;
      op_out      <= 2'd0;
      op_count    <= 4'd0;
      issue_valid <= 1'b0;
    end else begin
      // Synchronizer runs regardless of ena so no edge is lost while held
      sync1       <= load_btn;
      sync2       <= sync1;
      deb_cnt     <= deb_cnt_d;
      deb_lvl     <= deb_lvl_d;
      if (ena) deb_prev <= deb_lvl;
      state_q     <= state_d;
      a_out       <= a_d;
      b_out       <= b_d;
      op_out      <= op_d;
      op_count    <= count_d;
      issue_valid <= (state_d == ISSUE);
    end
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with DEBOUNCE_CYCLES = 4 (capture 7 cycles after press).
module tb_alu_operand_sequencer;

  logic       clk = 1'b0;
  logic       reset, ena, load_btn, issue_ready, issue_valid;
  logic [3:0] din, a_out, b_out, op_count;
  logic [1:0] op_in, op_out, stage;
  int         tests = 0;
  int         fails = 0;

  alu_operand_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .ena(ena), .din(din), .op_in(op_in),
    .load_btn(load_btn), .a_out(a_out), .b_out(b_out), .op_out(op_out),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .stage(stage),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Clean press: capture lands on the 7th edge, release settles within 8 more
  task automatic press(input logic [3:0] d, input logic [1:0] op);
    din = d; op_in = op; load_btn = 1'b1;
    step(7);
    load_btn = 1'b0;
    step(8);
  endtask

  task automatic test_reset();
    reset = 1'b1; load_btn = 1'b1; din = 4'h7; op_in = 2'b00;
    ena = 1'b1; issue_ready = 1'b0;
    step(2);
    tests++; if ({a_out, b_out, op_out, issue_valid, stage, op_count} !== 19'd0) begin
      fails++; $display("FAIL reset_outputs got %h required 0", {a_out, b_out, op_out, issue_valid, stage, op_count});
    end
    reset = 1'b0;
    step(6);
    tests++; if (stage !== 2'b00) begin fails++; $display("FAIL reset_held_early got %b required 00", stage); end
    step(1);
    tests++; if (stage !== 2'b01 || a_out !== 4'h7) begin
      fails++; $display("FAIL reset_held_pulse got stage=%b a=%h required 01/7", stage, a_out);
    end
    load_btn = 1'b0;
    step(8);
    reset = 1'b1; step(1); reset = 1'b0;
    tests++; if (stage !== 2'b00 || a_out !== 4'h0) begin
      fails++; $display("FAIL reset_clear got stage=%b a=%h required 00/0", stage, a_out);
    end
  endtask

  task automatic test_full_op();
    press(4'h5, 2'b00);
    tests++; if (stage !== 2'b01 || a_out !== 4'h5 || issue_valid !== 1'b0) begin
      fails++; $display("FAIL full_a got stage=%b a=%h v=%b required 01/5/0", stage, a_out, issue_valid);
    end
    press(4'h3, 2'b01);
    tests++; if (stage !== 2'b10 || b_out !== 4'h3 || op_out !== 2'b01 || issue_valid !== 1'b1) begin
      fails++; $display("FAIL full_b got stage=%b b=%h op=%b v=%b required 10/3/01/1", stage, b_out, op_out, issue_valid);
    end
    issue_ready = 1'b1;
    step(1);
    issue_ready = 1'b0;
    tests++; if (stage !== 2'b00 || issue_valid !== 1'b0 || op_count !== 4'd1 || a_out !== 4'h5) begin
      fails++; $display("FAIL full_accept got stage=%b v=%b cnt=%0d a=%h required 00/0/1/5", stage, issue_valid, op_count, a_out);
    end
  endtask

  task automatic test_bounce();
    din = 4'hA;
    for (int i = 0; i < 20; i++) begin
      load_btn = ((i / 2) % 2 == 0);
      step(1);
      tests++; if (stage !== 2'b00) begin fails++; $display("FAIL bounce_toggle i=%0d got stage=%b required 00", i, stage); end
    end
    load_btn = 1'b1;
    step(6);
    tests++; if (stage !== 2'b00 || a_out !== 4'h5) begin
      fails++; $display("FAIL bounce_early got stage=%b a=%h required 00/5", stage, a_out);
    end
    step(1);
    tests++; if (stage !== 2'b01 || a_out !== 4'hA) begin
      fails++; $display("FAIL bounce_capture got stage=%b a=%h required 01/a", stage, a_out);
    end
    load_btn = 1'b0;
    step(8);
  endtask

  task automatic test_backpressure();
    press(4'h2, 2'b10);
    din = 4'hF; op_in = 2'b11; load_btn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      tests++; if (issue_valid !== 1'b1 || a_out !== 4'hA || b_out !== 4'h2 || op_out !== 2'b10) begin
        fails++; $display("FAIL bp_hold i=%0d got v=%b a=%h b=%h op=%b required 1/a/2/10", i, issue_valid, a_out, b_out, op_out);
      end
    end
    load_btn = 1'b0;
    step(8);
    issue_ready = 1'b1;
    step(1);
    tests++; if (stage !== 2'b00 || issue_valid !== 1'b0 || op_count !== 4'd2) begin
      fails++; $display("FAIL bp_accept got stage=%b v=%b cnt=%0d required 00/0/2", stage, issue_valid, op_count);
    end
    step(1);
    issue_ready = 1'b0;
    tests++; if (op_count !== 4'd2 || a_out !== 4'hA) begin
      fails++; $display("FAIL bp_single got cnt=%0d a=%h required 2/a", op_count, a_out);
    end
  endtask

  task automatic test_wrap_ena();
    for (int i = 0; i < 14; i++) begin
      press(4'(i), 2'b00);
      press(4'(i + 1), 2'b01);
      issue_ready = 1'b1; step(1); issue_ready = 1'b0;
      if (i == 12) begin
        tests++; if (op_count !== 4'd15) begin fails++; $display("FAIL wrap_15 got %0d required 15", op_count); end
      end
    end
    tests++; if (op_count !== 4'd0 || stage !== 2'b00) begin
      fails++; $display("FAIL wrap_0 got cnt=%0d stage=%b required 0/00", op_count, stage);
    end
    din = 4'h6; load_btn = 1'b1;
    step(3);
    ena = 1'b0;
    step(5);
    ena = 1'b1;
    step(3);
    tests++; if (stage !== 2'b00) begin fails++; $display("FAIL ena_early got stage=%b required 00", stage); end
    step(1);
    tests++; if (stage !== 2'b01 || a_out !== 4'h6) begin
      fails++; $display("FAIL ena_delay got stage=%b a=%h required 01/6", stage, a_out);
    end
    load_btn = 1'b0;
    step(8);
  endtask

  task automatic test_midop_reset();
    reset = 1'b1; step(1); reset = 1'b0;
    press(4'h9, 2'b00);
    tests++; if (stage !== 2'b01 || a_out !== 4'h9) begin
      fails++; $display("FAIL midop_setup got stage=%b a=%h required 01/9", stage, a_out);
    end
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    tests++; if (stage !== 2'b00 || a_out !== 4'h0 || op_count !== 4'd0 || issue_valid !== 1'b0) begin
      fails++; $display("FAIL midop_reset got stage=%b a=%h cnt=%0d v=%b required 00/0/0/0", stage, a_out, op_count, issue_valid);
    end
  endtask

  initial begin
    test_reset();
    test_full_op();
    test_bounce();
    test_backpressure();
    test_wrap_ena();
    test_midop_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
